pattern_gen: RTL and testbench

Pattern generator: the transmit-direction counterpart of the capture block. It consumes sample words from an AXI-stream source (normally the axisfifo master port fed by DMA) and drives them onto a parallel output bus at the rate set by a clock divider. Arm/abort/done control, an underrun flag and the stream/length rules mirror the capture block, so firmware drives both blocks the same way.

---
 rtl/pattern_gen_pkg.sv | 25 ++
 rtl/pattern_gen_ckdiv_tick.sv | 39 +++
 rtl/pattern_gen.sv | 160 ++++++++++++++++
 tb/tb_pattern_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
//   Types and helpers shared by the pattern generator and the capture block.
//   - pg_state_t  : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - SADDR_W_DEF : default width of the length and sample counters
//   - div_width() : width of the clock-divider ratio input for a given
//                   maximum divider ratio
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pg_state_t;

  localparam int SADDR_W_DEF = 24;

  // $clog2 of the maximum ratio; clamped to 1 so a degenerate max_div
  // still yields a legal (one-bit) port.
  function automatic int div_width(input int max_div);
    return (max_div < 2) ? 1 : $clog2(max_div);
  endfunction

endpackage

// File: rtl/pattern_gen_ckdiv_tick.sv
// -----------------------------------------------------------------------------
// ckdiv_tick
//   Clock-divider counter producing a one-cycle tick every ckdiv+1 cycles.
//   Shared by the pattern generator and the capture block.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous reset, active-high
//     clr    in   synchronous clear; holds the counter at 0 and blocks tick
//     ckdiv  in   divider ratio minus one, sampled every cycle
//     tick   out  high on the cycle the counter reaches (or exceeds) ckdiv
// -----------------------------------------------------------------------------
module ckdiv_tick #(
  parameter int w = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [w-1:0] ckdiv,
  output logic         tick
);

  logic [w-1:0] div_cnt;

  // ">=" rather than "==": if ckdiv is lowered below the current count the
  // counter ticks and wraps at once instead of running all the way round.
  assign tick = !clr && (div_cnt >= ckdiv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//   Transmit-direction pattern generator. Pulls sample words from an
//   AXI-stream source and presents them on a parallel bus, one word per
//   divider period, under arm/abort control.
//
//   Handshake: a stream word is transferred on a cycle where tvalid and
//   tready are both high. tready is combinational, high only in RUN on a
//   divider tick and never in a cycle where abort is asserted; tvalid may
//   rise or fall on any cycle and the word is only consumed on a transfer.
//
//   Ports:
//     clk, reset         clock; asynchronous active-high reset
//     tdata/tvalid/tlast stream input; tready accepts a word
//     ckdiv              output period = ckdiv+1 clk cycles
//     arm, abort         start / stop pulses (abort has priority)
//     pattern_len        words to emit; 0 = run until tlast
//     idle_level         bus value while idle
//     doutput, dstrobe   generated bus and its one-cycle update pulse
//     running, done      in RUN / sticky completion flag
//     underrun           sticky; a tick found no stream data
//     sample_count       words emitted since arm (saturating)
//     state_dbg          current controller state (pg_state_t encoding)
// -----------------------------------------------------------------------------
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int size    = 32,
  parameter int max_div = 32,
  parameter int saddr_w = SADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [size-1:0]                tdata,
  input  logic                           tvalid,
  output logic                           tready,
  input  logic                           tlast,
  input  logic [div_width(max_div)-1:0]  ckdiv,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [saddr_w-1:0]             pattern_len,
  input  logic [size-1:0]                idle_level,
  output logic [size-1:0]                doutput,
  output logic                           dstrobe,
  output logic                           running,
  output logic                           done,
  output logic                           underrun,
  output logic [saddr_w-1:0]             sample_count,
  output logic [1:0]                     state_dbg
);

  localparam int DIV_W = div_width(max_div);
  localparam logic [saddr_w:0] CNT_ONE = 1;

  pg_state_t state, state_nxt;

  logic [size-1:0]    dout_nxt;
  logic               strobe_nxt;
  logic               done_nxt;
  logic               underrun_nxt;
  logic [saddr_w-1:0] count_nxt;

  logic               tick;
  logic [saddr_w:0]   count_inc;
  logic [saddr_w-1:0] count_sat;
  logic               end_hit;

  // The divider only runs in RUN; every other state holds it at zero, which
  // also gives the "clear on arm" behaviour for free.
  ckdiv_tick #(
    .w(DIV_W)
  ) u_ckdiv_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ST_RUN),
    .ckdiv (ckdiv),
    .tick  (tick)
  );

  assign tready    = (state == ST_RUN) && tick && !abort;
  assign running   = (state == ST_RUN);
  assign state_dbg = state;

  // One extra bit so the length compare stays exact even when the count is
  // saturated at all-ones.
  assign count_inc = {1'b0, sample_count} + CNT_ONE;
  assign count_sat = (sample_count == '1) ? sample_count : count_inc[saddr_w-1:0];
  assign end_hit   = tlast || ((pattern_len != '0) && (count_inc == {1'b0, pattern_len}));

  always_comb begin
    state_nxt    = state;
    dout_nxt     = doutput;
    strobe_nxt   = 1'b0;
    done_nxt     = done;
    underrun_nxt = underrun;
    count_nxt    = sample_count;

    if (abort) begin
      state_nxt = ST_IDLE;
      dout_nxt  = idle_level;
    end else begin
      case (state)
        ST_IDLE: begin
          dout_nxt = idle_level;
          if (arm) begin
            state_nxt    = ST_RUN;
            done_nxt     = 1'b0;
            underrun_nxt = 1'b0;
            count_nxt    = '0;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (tvalid) begin
              dout_nxt   = tdata;
              strobe_nxt = 1'b1;
              count_nxt  = count_sat;
              if (end_hit) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end
            end else begin
              underrun_nxt = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (arm) begin
            state_nxt    = ST_RUN;
            done_nxt     = 1'b0;
            underrun_nxt = 1'b0;
            count_nxt    = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      doutput      <= '0;
      dstrobe      <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      sample_count <= '0;
    end else begin
      state        <= state_nxt;
      doutput      <= dout_nxt;
      dstrobe      <= strobe_nxt;
      done         <= done_nxt;
      underrun     <= underrun_nxt;
      sample_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//   Directed bench for pattern_gen: per-cycle vector tables for the basic
//   length-terminated run and the abort case, plus a stream driver task for
//   divided-rate, underrun and re-arm sequences.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [4:0]  ckdiv;
  logic        arm;
  logic        abort;
  logic [23:0] pattern_len;
  logic [31:0] idle_level;
  logic [31:0] doutput;
  logic        dstrobe;
  logic        running;
  logic        done;
  logic        underrun;
  logic [23:0] sample_count;
  logic [1:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  pattern_gen #(
    .size(32), .max_div(32), .saddr_w(24)
  ) dut (
    .clk(clk), .reset(reset),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .ckdiv(ckdiv), .arm(arm), .abort(abort), .pattern_len(pattern_len),
    .idle_level(idle_level), .doutput(doutput), .dstrobe(dstrobe),
    .running(running), .done(done), .underrun(underrun),
    .sample_count(sample_count), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        abort;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        e_tready;
    logic [31:0] e_dout;
    logic        e_strobe;
    logic        e_running;
    logic        e_done;
    logic        e_underrun;
    logic [23:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic a, input logic ab, input logic v,
                              input logic l, input logic [31:0] d,
                              input logic etr, input logic [31:0] edo,
                              input logic est, input logic eru, input logic edn,
                              input logic eun, input logic [23:0] ecn);
    vec_t r;
    r.arm = a; r.abort = ab; r.tvalid = v; r.tlast = l; r.tdata = d;
    r.e_tready = etr; r.e_dout = edo; r.e_strobe = est; r.e_running = eru;
    r.e_done = edn; r.e_underrun = eun; r.e_cnt = ecn;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply the queued per-cycle vectors: drive at the falling edge, compare
  // 1 time unit later (combinational tready plus registered outputs).
  task automatic apply_vectors(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      arm = vecs[i].arm; abort = vecs[i].abort; tvalid = vecs[i].tvalid;
      tlast = vecs[i].tlast; tdata = vecs[i].tdata;
      #1;
      chk({tag, "_tready"},   64'(tready),       64'(vecs[i].e_tready));
      chk({tag, "_dout"},     64'(doutput),      64'(vecs[i].e_dout));
      chk({tag, "_strobe"},   64'(dstrobe),      64'(vecs[i].e_strobe));
      chk({tag, "_running"},  64'(running),      64'(vecs[i].e_running));
      chk({tag, "_done"},     64'(done),         64'(vecs[i].e_done));
      chk({tag, "_underrun"}, 64'(underrun),     64'(vecs[i].e_underrun));
      chk({tag, "_count"},    64'(sample_count), 64'(vecs[i].e_cnt));
    end
    vecs.delete();
    arm = 1'b0; abort = 1'b0; tlast = 1'b0;
  endtask

  // Arm, then stream nw words (base, base+1, ...) with tvalid held high
  // except on tick number 'gap' (0-based; -1 = none). tlast marks word nw-1.
  task automatic run_stream(input string tag, input int div, input int nw,
                            input int plen, input int gap, input int ncyc,
                            input logic [31:0] base, input logic [31:0] init_dout);
    logic [31:0] e_dout;
    logic        e_acc, e_und, e_done, fin, tick_c, gap_now;
    logic [1:0]  prev_st;
    int          k, ti, n_done_entry;
    e_dout = init_dout; e_acc = 1'b0; e_und = 1'b0; e_done = 1'b0; fin = 1'b0;
    k = 0; n_done_entry = 0;
    @(negedge clk);
    arm = 1'b1; abort = 1'b0; ckdiv = 5'(div); pattern_len = 24'(plen);
    tvalid = 1'b1; tdata = base; tlast = 1'b0;
    #1 chk({tag, "_arm_tready"}, 64'(tready), 64'(0));
    prev_st = state_dbg;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      arm = 1'b0;
      tick_c  = (c % (div + 1)) == 0;
      ti      = c / (div + 1) - 1;
      gap_now = tick_c && (ti == gap) && !fin;
      tvalid  = !gap_now;
      tdata   = base + 32'(k);
      tlast   = (k == nw - 1);
      #1;
      chk({tag, "_tready"},   64'(tready),       64'(tick_c && !fin));
      chk({tag, "_strobe"},   64'(dstrobe),      64'(e_acc));
      chk({tag, "_dout"},     64'(doutput),      64'(e_dout));
      chk({tag, "_underrun"}, 64'(underrun),     64'(e_und));
      chk({tag, "_done"},     64'(done),         64'(e_done));
      chk({tag, "_running"},  64'(running),      64'(!e_done));
      chk({tag, "_count"},    64'(sample_count), 64'(k));
      if (state_dbg == 2'd2 && prev_st != 2'd2) n_done_entry++;
      prev_st = state_dbg;
      e_acc = 1'b0;
      if (tick_c && !fin) begin
        if (gap_now) begin
          e_und = 1'b1;
        end else begin
          e_dout = base + 32'(k);
          e_acc  = 1'b1;
          k++;
          if (k == nw) fin = 1'b1;
        end
      end
      e_done = fin;
    end
    chk({tag, "_done_entries"}, 64'(n_done_entry), 64'(1));
    tlast = 1'b0;
  endtask

  initial begin
    // reset block
    reset = 1'b1; arm = 1'b0; abort = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; ckdiv = '0; pattern_len = '0; idle_level = 32'h11;
    #12;
    chk("rst_dout",     64'(doutput),      64'(0));
    chk("rst_strobe",   64'(dstrobe),      64'(0));
    chk("rst_running",  64'(running),      64'(0));
    chk("rst_done",     64'(done),         64'(0));
    chk("rst_underrun", 64'(underrun),     64'(0));
    chk("rst_count",    64'(sample_count), 64'(0));
    chk("rst_tready",   64'(tready),       64'(0));
    chk("rst_state",    64'(state_dbg),    64'(0));
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("idle_follow", 64'(doutput), 64'(32'h11));

    // Test 1: ckdiv=0, pattern_len=4, words 1..4 always valid
    ckdiv = 5'd0; pattern_len = 24'd4;
    vecs.push_back(mk(1,0,1,0,32'h1, 0,32'h11,0,0,0,0,24'd0));
    vecs.push_back(mk(0,0,1,0,32'h1, 1,32'h11,0,1,0,0,24'd0));
    vecs.push_back(mk(0,0,1,0,32'h2, 1,32'h1, 1,1,0,0,24'd1));
    vecs.push_back(mk(0,0,1,0,32'h3, 1,32'h2, 1,1,0,0,24'd2));
    vecs.push_back(mk(0,0,1,0,32'h4, 1,32'h3, 1,1,0,0,24'd3));
    vecs.push_back(mk(0,0,1,0,32'h5, 0,32'h4, 1,0,1,0,24'd4));
    vecs.push_back(mk(0,0,1,0,32'h5, 0,32'h4, 0,0,1,0,24'd4));
    apply_vectors("t1");

    // Test 4: abort from DONE, then arm, two words, abort mid-run
    @(negedge clk); abort = 1'b1; idle_level = 32'hA5A5A5A5;
    #1 chk("t4_abort_tready", 64'(tready), 64'(0));
    @(negedge clk); abort = 1'b0;
    #1;
    chk("t4_idle_dout",  64'(doutput),   64'(32'hA5A5A5A5));
    chk("t4_idle_done",  64'(done),      64'(1));
    chk("t4_idle_state", 64'(state_dbg), 64'(0));
    pattern_len = 24'd0;
    vecs.push_back(mk(1,0,1,0,32'h100, 0,32'hA5A5A5A5,0,0,1,0,24'd4));
    vecs.push_back(mk(0,0,1,0,32'h100, 1,32'hA5A5A5A5,0,1,0,0,24'd0));
    vecs.push_back(mk(0,0,1,0,32'h101, 1,32'h100,     1,1,0,0,24'd1));
    vecs.push_back(mk(0,1,1,0,32'h102, 0,32'h101,     1,1,0,0,24'd2));
    vecs.push_back(mk(0,0,1,0,32'h102, 0,32'hA5A5A5A5,0,0,0,0,24'd2));
    vecs.push_back(mk(0,0,1,0,32'h102, 0,32'hA5A5A5A5,0,0,0,0,24'd2));
    apply_vectors("t4");

    // Test 2: ckdiv=3, length 0, tlast on word 3
    run_stream("t2", 3, 3, 0, -1, 15, 32'h10, 32'hA5A5A5A5);

    // Test 3: ckdiv=1, tvalid low on the second tick
    run_stream("t3", 1, 3, 0, 1, 11, 32'h40, 32'h12);

    // Test 5: arm and abort together from IDLE, then async reset mid-run
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk); arm = 1'b1; abort = 1'b1; tvalid = 1'b1;
    #1 chk("t5_both_tready", 64'(tready), 64'(0));
    @(negedge clk); arm = 1'b0; abort = 1'b0;
    #1;
    chk("t5_both_state",   64'(state_dbg), 64'(0));
    chk("t5_both_running", 64'(running),   64'(0));
    chk("t5_both_tready2", 64'(tready),    64'(0));
    @(negedge clk); ckdiv = 5'd0; pattern_len = 24'd0; arm = 1'b1;
    @(negedge clk); arm = 1'b0; tdata = 32'h55;
    @(negedge clk); tdata = 32'h56;
    #1;
    chk("t5_run_dout",    64'(doutput), 64'(32'h55));
    chk("t5_run_running", 64'(running), 64'(1));
    reset = 1'b1;
    #1;
    chk("t5_arst_dout",    64'(doutput),      64'(0));
    chk("t5_arst_strobe",  64'(dstrobe),      64'(0));
    chk("t5_arst_running", 64'(running),      64'(0));
    chk("t5_arst_count",   64'(sample_count), 64'(0));
    chk("t5_arst_tready",  64'(tready),       64'(0));
    chk("t5_arst_state",   64'(state_dbg),    64'(0));
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    #1 chk("t6_idle_dout", 64'(doutput), 64'(32'hA5A5A5A5));

    // Test 6: pattern_len=2 with tlast on word 2, then re-arm and replay
    run_stream("t6a", 0, 2, 2, -1, 5, 32'h200, 32'hA5A5A5A5);
    run_stream("t6b", 0, 2, 2, -1, 5, 32'h300, 32'h201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
